// File: rtl/hazard_stall_controller_pkg.sv
// ---------------------------------------------------------------------------
// hazard_stall_controller_pkg
// Shared pipeline-control definitions: memory-wait state encoding, default
// register-address width and the strobe bundle that the pipeline top
// distributes to the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
// ---------------------------------------------------------------------------
package hazard_stall_controller_pkg;

  // Default register-address width of source/destination fields.
  localparam int REG_W_DEF = 4;

  // Memory-wait state machine encoding.
  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } wait_state_e;

  // Control strobes consumed by the pipeline registers and the PC.
  typedef struct packed {
    logic pc_freez;
    logic ifid_freez;
    logic ifid_flush;
    logic idex_flush;
    logic pipe_freez;
  } strobe_t;

  // Bundle with every strobe inactive.
  localparam strobe_t STROBES_IDLE = strobe_t'(5'b00000);

endpackage

// File: rtl/hazard_stall_controller_hazard_compare.sv
// ---------------------------------------------------------------------------
// hazard_compare
// Combinational data-hazard detector: compares the ID source registers with
// the EXE and MEM destinations and reports whether ID must stall.
//
// Ports
//   id_src1_i, id_src2_i   source registers of the ID instruction
//   id_two_src_i           ID instruction reads id_src2_i
//   exe_dest_i, mem_dest_i destination registers in EXE / MEM
//   exe_wb_en_i            EXE instruction writes back
//   mem_wb_en_i            MEM instruction writes back
//   exe_mem_read_i         EXE instruction is a load
//   forward_en_i           forwarding unit active
//   hazard_o               ID instruction must stall
// ---------------------------------------------------------------------------
module hazard_compare
  import hazard_stall_controller_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] id_src1_i,
  input  logic [REG_W-1:0] id_src2_i,
  input  logic             id_two_src_i,
  input  logic [REG_W-1:0] exe_dest_i,
  input  logic [REG_W-1:0] mem_dest_i,
  input  logic             exe_wb_en_i,
  input  logic             mem_wb_en_i,
  input  logic             exe_mem_read_i,
  input  logic             forward_en_i,
  output logic             hazard_o
);

  logic exe_match;
  logic mem_match;

  // Source/destination matching and hazard selection.
  always_comb begin
    exe_match = (exe_dest_i == id_src1_i) ||
                (id_two_src_i && (exe_dest_i == id_src2_i));
    mem_match = (mem_dest_i == id_src1_i) ||
                (id_two_src_i && (mem_dest_i == id_src2_i));
    if (forward_en_i) begin
      // With forwarding, only a load in EXE cannot supply its value in time.
      hazard_o = exe_wb_en_i && exe_mem_read_i && exe_match;
    end else begin
      hazard_o = (exe_wb_en_i && exe_match) || (mem_wb_en_i && mem_match);
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// ---------------------------------------------------------------------------
// hazard_stall_controller
// Producer of the IF/ID pipeline-register control strobes and the PC hold.
// Merges a multi-cycle memory-wait stall, branch-taken flush and data-hazard
// stall (in that priority), tracks the memory wait with a two-state machine,
// raises a sticky timeout for over-long waits and keeps saturating
// stall/flush performance counters.
//
// Ports
//   clock, reset              rising-edge clock, async active-high reset
//   id_src1, id_src2          ID source registers
//   id_two_src                ID instruction reads id_src2
//   exe_dest, mem_dest        EXE / MEM destination registers
//   exe_wb_en, mem_wb_en      EXE / MEM write-back enables
//   exe_mem_read              EXE instruction is a load
//   forward_en                forwarding unit active
//   branch_taken              EXE resolved a taken branch
//   mem_req, mem_ready        data-memory access request / completion
//   pc_freez, ifid_freez      hold PC / IF/ID register
//   ifid_flush, idex_flush    clear IF/ID / bubble into ID/EX
//   pipe_freez                hold ID/EX, EX/MEM, MEM/WB registers
//   mem_timeout               sticky: memory wait exceeded MAX_WAIT
//   stall_cycles, flush_count saturating performance counters
// ---------------------------------------------------------------------------
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int REG_W    = REG_W_DEF,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic [REG_W-1:0] exe_dest,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             exe_wb_en,
  input  logic             mem_wb_en,
  input  logic             exe_mem_read,
  input  logic             forward_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_freez,
  output logic             ifid_freez,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_freez,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  // Wait counter must hold MAX_WAIT+1, its saturation value.
  localparam int                WAIT_W   = $clog2(MAX_WAIT + 2);
  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  wait_state_e       state_q,     state_d;
  logic [WAIT_W-1:0] wait_cnt_q,  wait_cnt_d;
  logic              timeout_q,   timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic    hazard;
  logic    mem_stall;
  strobe_t strobes;

  hazard_compare #(
    .REG_W (REG_W)
  ) u_hazard_compare (
    .id_src1_i      (id_src1),
    .id_src2_i      (id_src2),
    .id_two_src_i   (id_two_src),
    .exe_dest_i     (exe_dest),
    .mem_dest_i     (mem_dest),
    .exe_wb_en_i    (exe_wb_en),
    .mem_wb_en_i    (mem_wb_en),
    .exe_mem_read_i (exe_mem_read),
    .forward_en_i   (forward_en),
    .hazard_o       (hazard)
  );

  // A stall is active for the whole wait, including the cycle ready arrives,
  // and already in the first cycle a request goes unanswered.
  assign mem_stall = (state_q == MEM_WAIT) || (mem_req && !mem_ready);

  // Strobe priority: memory stall, then branch flush, then data hazard.
  always_comb begin
    strobes = STROBES_IDLE;
    if (reset) begin
      strobes = STROBES_IDLE;
    end else if (mem_stall) begin
      // Whole pipeline holds; a pending branch stays in EXE until released.
      strobes.pc_freez   = 1'b1;
      strobes.ifid_freez = 1'b1;
      strobes.pipe_freez = 1'b1;
    end else if (branch_taken) begin
      // PC loads the branch target, so any concurrent hazard is moot.
      strobes.ifid_flush = 1'b1;
      strobes.idex_flush = 1'b1;
    end else if (hazard) begin
      strobes.pc_freez   = 1'b1;
      strobes.ifid_freez = 1'b1;
      strobes.idex_flush = 1'b1;
    end else begin
      strobes = STROBES_IDLE;
    end
  end

  assign pc_freez     = strobes.pc_freez;
  assign ifid_freez   = strobes.ifid_freez;
  assign ifid_flush   = strobes.ifid_flush;
  assign idex_flush   = strobes.idex_flush;
  assign pipe_freez   = strobes.pipe_freez;
  assign mem_timeout  = timeout_q;
  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;

  // Memory-wait state machine, wait counter and sticky timeout.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_ONE;
        end else begin
          // Idle or zero-wait access: stay running.
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (wait_cnt_q != WAIT_SAT) begin
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end else begin
          wait_cnt_d = wait_cnt_q;
        end
        // Dropping mem_req without ready does not abandon the wait.
        if (mem_ready) begin
          state_d = RUN;
        end else begin
          state_d = MEM_WAIT;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
    // wait_cnt_d is the number of wait cycles elapsed once this edge closes.
    if (mem_stall && !mem_ready && (wait_cnt_d >= WAIT_LIM)) begin
      timeout_d = 1'b1;
    end else begin
      timeout_d = timeout_q;
    end
  end

  // Saturating performance counters, stepped by this cycle's strobes.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (strobes.pc_freez && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (strobes.ifid_flush && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // State and counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_controller
// Directed bench with a behavioural model of the stall/flush rules; small
// counter and timeout limits make saturation and timeout reachable quickly.
// ---------------------------------------------------------------------------
module tb_hazard_stall_controller;

  localparam int REG_W    = 4;
  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 8;
  localparam int CNT_TOP  = (1 << CNT_W) - 1;

  logic             clock;
  logic             reset;
  logic [REG_W-1:0] id_src1, id_src2, exe_dest, mem_dest;
  logic             id_two_src, exe_wb_en, mem_wb_en, exe_mem_read;
  logic             forward_en, branch_taken, mem_req, mem_ready;
  logic             pc_freez, ifid_freez, ifid_flush, idex_flush, pipe_freez;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  hazard_stall_controller #(
    .REG_W    (REG_W),
    .CNT_W    (CNT_W),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_two_src   (id_two_src),
    .exe_dest     (exe_dest),
    .mem_dest     (mem_dest),
    .exe_wb_en    (exe_wb_en),
    .mem_wb_en    (mem_wb_en),
    .exe_mem_read (exe_mem_read),
    .forward_en   (forward_en),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .pc_freez     (pc_freez),
    .ifid_freez   (ifid_freez),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .pipe_freez   (pipe_freez),
    .mem_timeout  (mem_timeout),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  // Model state: waiting flag, elapsed wait cycles, timeout, counters.
  bit m_waiting;
  int m_waited;
  bit m_to;
  int m_stall;
  int m_flush;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
  endtask

  // Expected {pc_freez, ifid_freez, ifid_flush, idex_flush, pipe_freez}.
  function automatic logic [4:0] exp_strobes();
    bit hit_exe, hit_mem, hz;
    hit_exe = (exe_dest == id_src1) || (id_two_src && exe_dest == id_src2);
    hit_mem = (mem_dest == id_src1) || (id_two_src && mem_dest == id_src2);
    if (forward_en) hz = exe_wb_en && exe_mem_read && hit_exe;
    else            hz = (exe_wb_en && hit_exe) || (mem_wb_en && hit_mem);
    if (m_waiting || (mem_req && !mem_ready)) return 5'b11001;
    if (branch_taken)                         return 5'b00110;
    if (hz)                                   return 5'b11010;
    return 5'b00000;
  endfunction

  // Model advances on every clock edge that closes a cycle.
  always @(posedge clock or posedge reset) begin
    logic [4:0] e;
    int nw;
    if (reset) begin
      m_waiting = 1'b0; m_waited = 0; m_to = 1'b0; m_stall = 0; m_flush = 0;
    end else begin
      e = exp_strobes();
      if (e[4] && m_stall < CNT_TOP) m_stall = m_stall + 1;
      if (e[2] && m_flush < CNT_TOP) m_flush = m_flush + 1;
      if (m_waiting) begin
        nw = (m_waited < MAX_WAIT + 1) ? m_waited + 1 : m_waited;
        m_waited = nw;
        if (!mem_ready && nw >= MAX_WAIT) m_to = 1'b1;
        if (mem_ready) m_waiting = 1'b0;
      end else if (mem_req && !mem_ready) begin
        m_waiting = 1'b1;
        m_waited  = 1;
        if (1 >= MAX_WAIT) m_to = 1'b1;
      end
    end
  end

  // Compare process: every out-of-reset cycle, mid-cycle.
  always @(negedge clock) begin
    if (chk_en && !reset) begin
      check("strobes", {27'd0, pc_freez, ifid_freez, ifid_flush, idex_flush, pipe_freez},
            {27'd0, exp_strobes()});
      check("never_freeze_and_flush", {31'd0, ifid_freez & ifid_flush}, 32'd0);
      check("mem_timeout", {31'd0, mem_timeout}, {31'd0, m_to});
      check("stall_cycles", {28'd0, stall_cycles}, m_stall);
      check("flush_count", {28'd0, flush_count}, m_flush);
    end
  end

  task automatic clr();
    id_src1 = 4'd0; id_src2 = 4'd0; id_two_src = 1'b0;
    exe_dest = 4'd0; mem_dest = 4'd0; exe_wb_en = 1'b0; mem_wb_en = 1'b0;
    exe_mem_read = 1'b0; forward_en = 1'b0; branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic mid(); @(negedge clock); #1; endtask
  task automatic fin(); @(posedge clock); #1; endtask
  task automatic cyc(); mid(); fin(); endtask

  task automatic do_reset();
    reset = 1'b1;
    fin();
    reset = 1'b0;
  endtask

  task automatic load_use();
    forward_en = 1'b1; exe_mem_read = 1'b1; exe_wb_en = 1'b1;
    exe_dest = 4'd3; id_src1 = 4'd3;
  endtask

  initial begin
    clr();
    reset = 1'b1;
    fin();
    // Strobes must stay low while reset is held, whatever the inputs.
    mem_req = 1'b1; branch_taken = 1'b1; load_use();
    #1;
    check("reset_strobes", {27'd0, pc_freez, ifid_freez, ifid_flush, idex_flush, pipe_freez}, 32'd0);
    check("reset_stall_cycles", {28'd0, stall_cycles}, 32'd0);
    check("reset_timeout", {31'd0, mem_timeout}, 32'd0);
    fin();
    clr();
    reset = 1'b0;
    chk_en = 1'b1;

    // Load-use stall for one cycle.
    load_use();
    mid();
    check("lu_pc_freez", {31'd0, pc_freez}, 32'd1);
    check("lu_ifid_freez", {31'd0, ifid_freez}, 32'd1);
    check("lu_idex_flush", {31'd0, idex_flush}, 32'd1);
    fin();
    clr();
    mid();
    check("lu_stall_cycles", {28'd0, stall_cycles}, 32'd1);
    check("lu_released", {31'd0, pc_freez}, 32'd0);
    fin();
    // Forwarding on, EXE ALU write (not a load) matching: no stall.
    forward_en = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd6; id_src1 = 4'd6;
    mid();
    check("fwd_alu_nostall", {31'd0, pc_freez}, 32'd0);
    fin();

    // No forwarding: MEM destination against second source.
    clr();
    mem_dest = 4'd5; mem_wb_en = 1'b1; id_two_src = 1'b1; id_src2 = 4'd5; id_src1 = 4'd1;
    mid();
    check("nofwd_src2_stall", {31'd0, pc_freez}, 32'd1);
    fin();
    id_two_src = 1'b0;
    mid();
    check("nofwd_src2_unused", {31'd0, pc_freez}, 32'd0);
    fin();
    clr();
    exe_wb_en = 1'b1; exe_dest = 4'd7; id_src1 = 4'd7;
    cyc();
    exe_wb_en = 1'b0;
    cyc();
    clr();

    // Branch and hazard in the same cycle: branch wins.
    do_reset();
    load_use(); branch_taken = 1'b1;
    mid();
    check("br_ifid_flush", {31'd0, ifid_flush}, 32'd1);
    check("br_idex_flush", {31'd0, idex_flush}, 32'd1);
    check("br_pc_freez", {31'd0, pc_freez}, 32'd0);
    check("br_ifid_freez", {31'd0, ifid_freez}, 32'd0);
    fin();
    clr();
    mid();
    check("br_flush_count", {28'd0, flush_count}, 32'd1);
    fin();

    // Memory wait of 4 unready cycles plus ready cycle, branch held throughout.
    do_reset();
    mem_req = 1'b1; branch_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mid();
      check("mw_pipe_freez", {31'd0, pipe_freez}, 32'd1);
      check("mw_no_flush", {31'd0, ifid_flush}, 32'd0);
      fin();
    end
    mem_ready = 1'b1;
    mid();
    check("mw_ready_frozen", {31'd0, pipe_freez}, 32'd1);
    fin();
    mem_req = 1'b0; mem_ready = 1'b0;
    mid();
    check("mw_released", {31'd0, pipe_freez}, 32'd0);
    check("mw_branch_flush", {31'd0, ifid_flush}, 32'd1);
    fin();
    clr();
    mid();
    check("mw_stall_cycles", {28'd0, stall_cycles}, 32'd5);
    check("mw_flush_count", {28'd0, flush_count}, 32'd1);
    fin();

    // Zero-wait access, then a wait where mem_req drops before ready.
    mem_req = 1'b1; mem_ready = 1'b1;
    mid();
    check("zw_no_stall", {31'd0, pipe_freez}, 32'd0);
    fin();
    mem_ready = 1'b0;
    cyc();
    mem_req = 1'b0;
    mid();
    check("req_drop_still_wait", {31'd0, pipe_freez}, 32'd1);
    fin();
    cyc();
    mem_ready = 1'b1;
    cyc();
    clr();
    cyc();

    // Timeout: ready low for 10 cycles.
    do_reset();
    mem_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      mid();
      check("to_progress", {31'd0, mem_timeout}, (c <= MAX_WAIT) ? 32'd0 : 32'd1);
      check("to_still_stalled", {31'd0, pipe_freez}, 32'd1);
      fin();
    end
    mem_ready = 1'b1;
    cyc();
    clr();
    mid();
    check("to_sticky", {31'd0, mem_timeout}, 32'd1);
    check("to_released", {31'd0, pipe_freez}, 32'd0);
    fin();

    // Reset asserted mid-wait in cycle 10.
    do_reset();
    mem_req = 1'b1;
    repeat (9) cyc();
    mid();
    check("rw_pre_timeout", {31'd0, mem_timeout}, 32'd1);
    reset = 1'b1;
    #1;
    check("rw_strobes_drop", {27'd0, pc_freez, ifid_freez, ifid_flush, idex_flush, pipe_freez}, 32'd0);
    check("rw_timeout_clear", {31'd0, mem_timeout}, 32'd0);
    check("rw_stall_clear", {28'd0, stall_cycles}, 32'd0);
    fin();
    clr();
    reset = 1'b0;
    mid();
    check("rw_back_in_run", {31'd0, pipe_freez}, 32'd0);
    fin();

    // Saturation: 20 hazard cycles on a 4-bit counter.
    do_reset();
    load_use();
    repeat (20) cyc();
    clr();
    mid();
    check("sat_stall_cycles", {28'd0, stall_cycles}, 32'd15);
    fin();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
